// File: rtl/platform_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : platform_scheduler
// Description : Owns the 16-slot platform position table. Initialises the
//               ladder, decides per frame whether the world scrolls, walks the
//               table one slot per clock applying the shift, and respawns
//               platforms that fall off the bottom at the top with a fresh X.
// Revision    : 1.0 - initial release
// ============================================================================
module platform_scheduler #(
    parameter  int NUM_PLAT    = 16,
    parameter  int SPACING     = 30,
    parameter  int SCROLL_LINE = 160,
    parameter  int MAX_SHIFT   = 8,
    parameter  int X_MIN       = 20,
    localparam int IDX_W       = $clog2(NUM_PLAT)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             game_start,
    input  logic [9:0]       BallY,
    input  logic [9:0]       rand_val,
    input  logic [IDX_W-1:0] plat_idx_rd,
    output logic [9:0]       platX_rd,
    output logic [9:0]       platY_rd,
    output logic             busy,
    output logic             scroll_valid,
    output logic [9:0]       scroll_amt,
    output logic [15:0]      score
);

    localparam logic [9:0]       c_height = 10'(NUM_PLAT * SPACING);
    localparam logic [IDX_W-1:0] c_last   = IDX_W'(NUM_PLAT - 1);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [9:0]       r_x [NUM_PLAT];
    logic [9:0]       r_y [NUM_PLAT];
    logic [9:0]       r_shift;
    logic [9:0]       r_amt;
    logic [15:0]      r_score;
    logic             r_valid;
    logic             r_busy;

    logic [9:0] w_shift;
    logic [9:0] w_gap;
    logic [9:0] w_ny;
    logic       w_wrap;
    logic [9:0] w_new_x;
    logic [9:0] w_init_y;
    logic       w_unused_rand;

    // Only the low nine random bits select the respawn column.
    assign w_unused_rand = rand_val[9];

    // Scroll amount for the current ball row, clamped to the per-frame limit.
    assign w_gap   = 10'(SCROLL_LINE) - BallY;
    assign w_shift = (BallY < 10'(SCROLL_LINE))
                   ? ((w_gap > 10'(MAX_SHIFT)) ? 10'(MAX_SHIFT) : w_gap)
                   : 10'd0;

    // Per-slot update arithmetic; 479 + MAX_SHIFT still fits in 10 bits.
    assign w_ny     = r_y[r_idx] + r_shift;
    assign w_wrap   = (w_ny >= c_height);
    assign w_new_x  = 10'(X_MIN) + {1'b0, rand_val[8:0]};
    assign w_init_y = 10'(r_idx) * 10'(SPACING);

    // Asynchronous read port for the color mapper.
    assign platX_rd     = r_x[plat_idx_rd];
    assign platY_rd     = r_y[plat_idx_rd];
    assign busy         = r_busy;
    assign scroll_valid = r_valid;
    assign scroll_amt   = r_amt;
    assign score        = r_score;

    // Sequencer: table init, scroll decision, slot walk and completion pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_INIT;
            r_idx   <= '0;
            r_shift <= '0;
            r_amt   <= '0;
            r_score <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            for (int k = 0; k < NUM_PLAT; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
            end
        end else if (game_start) begin
            // Restart wins over everything, including a coincident frame tick.
            r_state <= S_INIT;
            r_idx   <= '0;
            r_score <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_x[r_idx] <= w_new_x;
                    r_y[r_idx] <= w_init_y;
                    if (r_idx == c_last) begin
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_IDLE: begin
                    if (frame_tick && (w_shift != 10'd0)) begin
                        r_shift <= w_shift;
                        r_idx   <= '0;
                        r_state <= S_UPDATE;
                        r_busy  <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (w_wrap) begin
                        r_y[r_idx] <= w_ny - c_height;
                        r_x[r_idx] <= w_new_x;
                        if (r_score != 16'hFFFF) begin
                            r_score <= r_score + 16'd1;
                        end
                    end else begin
                        r_y[r_idx] <= w_ny;
                    end
                    if (r_idx == c_last) begin
                        r_idx   <= '0;
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                        r_amt   <= r_shift;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_INIT;
                    r_idx   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
